// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Package  : seg7_pkg
// Brief    : Shared types, constants and BCD helpers for the 7-seg scanner
// Revision : 1.0
// ============================================================================
package seg7_pkg;

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } scan_state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // Width of a digit index; a single-digit bank still gets one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Adds cin to one BCD digit; returns {carry_out, digit}.
   function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic cin);
      logic [4:0] res;
      res = {1'b0, d};
      if (cin) begin
         if (d >= BCD_MAX) begin
            res = {1'b1, 4'd0};
         end else begin
            res = {1'b0, d + 4'd1};
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : seg7_scan_ctrl_if
// Brief     : Control, load handshake and display signals of the scanner
// Revision  : 1.0
// ============================================================================
interface seg7_scan_ctrl_if
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4
);
   localparam int IDX_W = idx_width(NUM_DIGITS);

   logic                    inc;
   logic                    clr;
   logic                    load_valid;
   logic                    load_ready;
   logic [4*NUM_DIGITS-1:0] load_data;
   logic [3:0]              bcd;
   logic [NUM_DIGITS-1:0]   digit_en;
   logic [IDX_W-1:0]        scan_idx;
   logic                    carry;

   modport master (
      output inc, clr, load_valid, load_data,
      input  load_ready, bcd, digit_en, scan_idx, carry
   );

   modport slave (
      input  inc, clr, load_valid, load_data,
      output load_ready, bcd, digit_en, scan_idx, carry
   );

endinterface
`default_nettype wire

// File: rtl/bcd_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter
// Brief    : NUM_DIGITS BCD up-counter with clr > load > inc priority
// Revision : 1.0
// ============================================================================
module bcd_counter
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    load,
   input  logic                    inc,
   input  logic [4*NUM_DIGITS-1:0] load_data,
   output logic [4*NUM_DIGITS-1:0] count,
   output logic                    carry
);

   logic [4*NUM_DIGITS-1:0] r_count;
   logic                    r_carry;
   logic [4*NUM_DIGITS-1:0] w_inc_val;
   logic [4*NUM_DIGITS-1:0] w_load_val;
   logic                    w_wrap;

   always_comb begin
      logic       c;
      logic [4:0] s;
      c          = 1'b1;
      s          = '0;
      w_inc_val  = '0;
      w_load_val = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         s                    = bcd_inc(r_count[4*i +: 4], c);
         w_inc_val[4*i +: 4]  = s[3:0];
         c                    = s[4];
         // Non-decimal nibbles are stored as zero.
         w_load_val[4*i +: 4] = (load_data[4*i +: 4] > BCD_MAX) ? 4'd0 : load_data[4*i +: 4];
      end
      w_wrap = c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_carry <= 1'b0;
      end else if (clr) begin
         r_count <= '0;
         r_carry <= 1'b0;
      end else if (load) begin
         r_count <= w_load_val;
         r_carry <= 1'b0;
      end else if (inc) begin
         r_count <= w_inc_val;
         r_carry <= w_wrap;
      end else begin
         r_carry <= 1'b0;
      end
   end

   assign count = r_count;
   assign carry = r_carry;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Brief    : Time-multiplexed scan of a BCD counter onto shared 7-seg digits
// Revision : 1.0
// ============================================================================
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst,
   seg7_scan_ctrl_if.slave bus
);

   localparam int IDX_W = idx_width(NUM_DIGITS);
   localparam int TMR_W = $clog2(SCAN_DIV + 1);

   localparam logic [TMR_W-1:0] c_blank_last = TMR_W'(BLANK_CYCLES - 1);
   localparam logic [TMR_W-1:0] c_show_last  = TMR_W'(SCAN_DIV - BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] c_last_idx   = IDX_W'(NUM_DIGITS - 1);

   scan_state_t             r_state;
   logic [TMR_W-1:0]        r_timer;
   logic [IDX_W-1:0]        r_idx;
   logic [4*NUM_DIGITS-1:0] r_snap;
   logic [3:0]              r_bcd;
   logic [NUM_DIGITS-1:0]   r_digit_en;
   logic                    r_load_ready;

   logic [4*NUM_DIGITS-1:0] w_count;
   logic                    w_carry;
   logic                    w_load_fire;
   logic [3:0]              w_count_digit;
   logic [3:0]              w_snap_digit;
   logic [NUM_DIGITS-1:0]   w_onehot;
   logic [IDX_W-1:0]        w_next_idx;

   assign w_load_fire = bus.load_valid & r_load_ready;

   bcd_counter #(
      .NUM_DIGITS (NUM_DIGITS)
   ) u_counter (
      .clk       (clk),
      .rst       (rst),
      .clr       (bus.clr),
      .load      (w_load_fire),
      .inc       (bus.inc),
      .load_data (bus.load_data),
      .count     (w_count),
      .carry     (w_carry)
   );

   // Digit selection by compare loop keeps non-power-of-two banks in range.
   always_comb begin
      w_count_digit = '0;
      w_snap_digit  = '0;
      w_onehot      = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_count_digit = w_count[4*i +: 4];
            w_snap_digit  = r_snap[4*i +: 4];
            w_onehot[i]   = 1'b1;
         end
      end
   end

   assign w_next_idx = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_BLANK;
         r_timer      <= '0;
         r_idx        <= '0;
         r_snap       <= '0;
         r_bcd        <= '0;
         r_digit_en   <= '0;
         r_load_ready <= 1'b0;
      end else begin
         r_load_ready <= 1'b1;
         case (r_state)
            ST_BLANK: begin
               if (r_timer == c_blank_last) begin
                  r_state    <= ST_SHOW;
                  r_timer    <= '0;
                  r_digit_en <= w_onehot;
                  // Frame start: latch the counter so the whole frame is coherent.
                  if (r_idx == '0) begin
                     r_snap <= w_count;
                     r_bcd  <= w_count_digit;
                  end else begin
                     r_bcd  <= w_snap_digit;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_SHOW: begin
               if (r_timer == c_show_last) begin
                  r_state    <= ST_BLANK;
                  r_timer    <= '0;
                  r_digit_en <= '0;
                  r_bcd      <= '0;
                  r_idx      <= w_next_idx;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            default: begin
               r_state <= ST_BLANK;
               r_timer <= '0;
            end
         endcase
      end
   end

   assign bus.load_ready = r_load_ready;
   assign bus.bcd        = r_bcd;
   assign bus.digit_en   = r_digit_en;
   assign bus.scan_idx   = r_idx;
   assign bus.carry      = w_carry;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Brief    : Self-checking bench for seg7_scan_ctrl (4 digits, 8-cycle slots)
// Revision : 1.0
// ============================================================================
module tb_seg7_scan_ctrl;

   typedef struct {
      logic [15:0] data;
      logic        do_inc;
      logic [15:0] exp_val;
      logic        exp_carry;
   } vec_t;

   typedef struct {
      logic [1:0] idx;
      logic [3:0] bcd;
   } slot_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   int    checks   = 0;
   int    failures = 0;
   slot_t exp_q[$];
   logic [3:0] prev_en = 4'b0;

   seg7_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

   seg7_scan_ctrl #(
      .NUM_DIGITS   (4),
      .SCAN_DIV     (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   // Scoreboard consumer: each new SHOW slot is compared against the queue head.
   always @(negedge clk) begin
      if (!rst && bus.digit_en != 4'b0 && prev_en == 4'b0 && exp_q.size() > 0) begin
         slot_t e;
         e = exp_q.pop_front();
         check("slot_digit_en", {28'b0, bus.digit_en}, {28'b0, 4'b0001 << e.idx});
         check("slot_scan_idx", {30'b0, bus.scan_idx}, {30'b0, e.idx});
         check("slot_bcd",      {28'b0, bus.bcd},      {28'b0, e.bcd});
      end
      prev_en = bus.digit_en;
   end

   task automatic push_frame(input logic [15:0] v);
      for (int i = 0; i < 4; i++) begin
         slot_t s;
         s.idx = 2'(i);
         s.bcd = v[4*i +: 4];
         exp_q.push_back(s);
      end
   endtask

   task automatic wait_show_start(input int idx);
      int n;
      n = 0;
      while (!(bus.digit_en == 4'b0 && bus.scan_idx == 2'(idx)) && n < 200) begin
         @(negedge clk);
         n++;
      end
      while (bus.digit_en == 4'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) timeout_fail("sync_show");
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) timeout_fail("scoreboard_drain");
   endtask

   // Load at the start of an idx3 slot so the value lands before the next frame.
   task automatic apply_vec(input vec_t v);
      wait_show_start(3);
      check("load_ready", {31'b0, bus.load_ready}, 32'd1);
      bus.load_valid = 1'b1;
      bus.load_data  = v.data;
      @(negedge clk);
      bus.load_valid = 1'b0;
      bus.inc        = v.do_inc;
      check("carry_after_load", {31'b0, bus.carry}, 32'd0);
      @(negedge clk);
      bus.inc = 1'b0;
      check("carry_pulse", {31'b0, bus.carry}, {31'b0, v.exp_carry});
      @(negedge clk);
      check("carry_clear", {31'b0, bus.carry}, 32'd0);
      push_frame(v.exp_val);
      wait_drain();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      vec_t v5555;
      vecs[0] = '{16'h1234, 1'b0, 16'h1234, 1'b0};
      vecs[1] = '{16'h00A9, 1'b0, 16'h0009, 1'b0};
      vecs[2] = '{16'h9999, 1'b1, 16'h0000, 1'b1};
      vecs[3] = '{16'h7B58, 1'b0, 16'h7058, 1'b0};
      vecs[4] = '{16'h0999, 1'b1, 16'h1000, 1'b0};
      vecs[5] = '{16'h0019, 1'b1, 16'h0020, 1'b0};
      v5555   = '{16'h5555, 1'b0, 16'h5555, 1'b0};

      bus.inc        = 1'b0;
      bus.clr        = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_data  = 16'h0;

      // Reset state and the free-running scan pattern after release.
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {bus.load_ready, bus.carry, bus.scan_idx, bus.bcd, bus.digit_en}, 32'h0);
      rst = 1'b0;
      for (int k = 0; k < 34; k++) begin
         logic [3:0] en_exp;
         int slot;
         slot   = (k / 8) % 4;
         en_exp = ((k % 8) >= 2) ? (4'b0001 << slot) : 4'b0000;
         check($sformatf("scan_k%0d", k),
               {22'b0, bus.scan_idx, bus.bcd, bus.digit_en},
               {22'b0, 2'(slot), 4'h0, en_exp});
         @(negedge clk);
      end

      for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

      // clr, load and inc together: clr wins, no carry, load is dropped.
      wait_show_start(3);
      check("load_ready_prio", {31'b0, bus.load_ready}, 32'd1);
      bus.clr        = 1'b1;
      bus.load_valid = 1'b1;
      bus.load_data  = 16'h5555;
      bus.inc        = 1'b1;
      @(negedge clk);
      bus.clr        = 1'b0;
      bus.load_valid = 1'b0;
      bus.inc        = 1'b0;
      check("prio_carry0", {31'b0, bus.carry}, 32'd0);
      @(negedge clk);
      check("prio_carry1", {31'b0, bus.carry}, 32'd0);
      push_frame(16'h0000);
      wait_drain();
      apply_vec(v5555);

      // Mid-frame change: rest of the frame keeps the old snapshot.
      wait_show_start(2);
      bus.load_valid = 1'b1;
      bus.load_data  = 16'h4321;
      @(negedge clk);
      bus.load_valid = 1'b0;
      check("midframe_idx2_bcd", {28'b0, bus.bcd}, 32'd5);
      begin
         slot_t s;
         s.idx = 2'd3;
         s.bcd = 4'd5;
         exp_q.push_back(s);
      end
      push_frame(16'h4321);
      wait_drain();

      // Asynchronous reset in the middle of a SHOW slot.
      wait_show_start(1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_outputs",
            {bus.load_ready, bus.carry, bus.scan_idx, bus.bcd, bus.digit_en}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_release_k0", {28'b0, bus.digit_en}, 32'h0);
      @(negedge clk);
      check("rst_release_k1", {28'b0, bus.digit_en}, 32'h0);
      @(negedge clk);
      check("rst_release_k2", {24'b0, bus.bcd, bus.digit_en}, 32'h01);

      if (exp_q.size() != 0) timeout_fail("scoreboard_leftover");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Multiplexed scan controller for a bank of common-anode 7-segment digits sharing one BCD-to-7-segment decoder.
- Holds a NUM_DIGITS-digit BCD up-counter, loadable via a valid/ready handshake.
- Time-slices the shared decoder input (W=bit0 … Z=bit3) across digits, with a blanking gap between slots to prevent ghosting.
- Sits between board-level control (push-button/tick logic) and the decoder plus digit-enable pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
SCAN_DIV, 1000, clock cycles per digit slot (SHOW + BLANK); must exceed BLANK_CYCLES
BLANK_CYCLES, 16, cycles per slot with all digit enables low; at least 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
inc  in  1  increment request, sampled each cycle
clr  in  1  synchronous clear of counter to all zeros
load_valid  in  1  load request
load_ready  out  1  load accepted when load_valid & load_ready
load_data  in  4*NUM_DIGITS  BCD digits, digit 0 (least significant) in bits [3:0]
bcd  out  4  to decoder W,X,Y,Z (bit0=W)
digit_en  out  NUM_DIGITS  one-hot digit enable, active-high
scan_idx  out  clog2(NUM_DIGITS) (min 1)  index of digit currently in slot
carry  out  1  one-cycle pulse on counter wrap from all-9s to all-0s

Behaviour:
- Reset (async assert, sync release): counter=0, display snapshot=0, state=BLANK, scan_idx=0, timer=0, bcd=0, digit_en=0, carry=0, load_ready=0.
- load_ready is registered: 0 during reset, 1 from the first clock after reset release, and stays 1.
- Counter priority per cycle: clr > accepted load > inc. When multiple are active, only the highest-priority action takes effect; the others are dropped, not queued.
- Load: any load_data digit > 9 is stored as 0; the other digits are stored unchanged.
- Increment: BCD ripple. Digit 0 +1; a 9 becomes 0 and carries into the next digit. If all digits are 9, the counter becomes all 0 and carry pulses high in the following cycle (registered). A load or clr never raises carry.
- Scan FSM, two states:
  - BLANK: digit_en=0, bcd=0. After BLANK_CYCLES cycles → SHOW with the same scan_idx.
  - SHOW: digit_en = one-hot(scan_idx); bcd = snapshot digit[scan_idx]. After SCAN_DIV-BLANK_CYCLES cycles → BLANK, scan_idx+1, wrapping NUM_DIGITS-1 → 0.
- Snapshot: the counter is copied into the display snapshot on the BLANK→SHOW transition when scan_idx==0. Each frame therefore shows one coherent value; counter changes mid-frame appear in the next frame.
- All outputs are registered. With the transition at edge k:
  - first cycle digit_en[0]=1 is cycle BLANK_CYCLES after reset release;
  - bcd and digit_en change on the same edge.
- NUM_DIGITS=1: scan_idx stays 0; BLANK/SHOW alternation still applies.
- Reset asserted mid-slot: outputs go to reset values immediately, without waiting for a clock; the scan restarts from BLANK, idx 0.

Decomposition:
- Shared package seg7_pkg holds:
  - state encoding constants ST_BLANK and ST_SHOW;
  - BCD_MAX = 9;
  - a function that increments one BCD digit and returns {carry, digit}.
- One natural sub-module: bcd_counter. It owns clr/load/inc priority, digit sanitising and carry generation, parameterised by NUM_DIGITS.
- The scan FSM, timer and snapshot live in the top level.

Test Plan:
(All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.)
- Reset release, no stimulus → digit_en=0000 for 2 cycles, then 0001 for 6 cycles with bcd=0, then 2 blank cycles, then 0010; the sequence repeats with period 32 cycles.
- Load 16'h1234 with load_valid for 1 cycle → accepted (load_ready=1). In the next frame, slots idx0..3 show bcd 4,3,2,1.
- Load 16'h9999, then pulse inc once → counter 0000 and carry=1 for exactly one cycle, one cycle after the inc edge. The next frame shows 0,0,0,0.
- Load 16'h00A9 → stored as 0009 (digit 1 value A sanitised to 0).
- Same cycle clr=1, load_valid=1 (data 5555), inc=1 → counter 0000, no carry. Then load_valid alone with 5555 → counter 5555.
- Change the counter while scan_idx=2 is in SHOW → bcd for idx2 and idx3 still reflects the old snapshot. The new value first appears at the next idx0 slot.
- Assert rst mid-SHOW asynchronously → digit_en=0, bcd=0 with no clock edge. After release, digit_en[0] first goes high 2 cycles later.
